// File: rtl/rr_arbiter16_pkg.sv
// Shared constants, FSM state type and the round-robin pick helper for the 16-way arbiter.
package rr_arbiter16_pkg;

    localparam int unsigned NumReq = 16;
    localparam int unsigned IdxW   = 4;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } arb_state_t;

    // First requester after ptr in circular order; ptr itself has the lowest priority.
    function automatic logic [IdxW-1:0] rr_pick(input logic [NumReq-1:0] req,
                                                input logic [IdxW-1:0]   ptr);
        logic [IdxW-1:0] pick;
        logic [IdxW-1:0] cand;
        pick = ptr;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = ptr + IdxW'(NumReq - i);
            if (req[cand]) pick = cand;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter16_if.sv
// Requester-side bus of the arbiter: request/control inputs and the grant outputs.
interface rr_arbiter16_if;
    import rr_arbiter16_pkg::*;

    logic                en;
    logic [NumReq-1:0]   req;
    logic                done;
    logic [0:NumReq-1]   grant;
    logic [IdxW-1:0]     idx;
    logic                valid;
    logic                timeout;

    modport master (
        output en, req, done,
        input  grant, idx, valid, timeout
    );

    modport slave (
        input  en, req, done,
        output grant, idx, valid, timeout
    );

endinterface

// File: rtl/rr_arbiter16_grant_decoder4t16.sv
// Combinational 4-to-16 one-hot decoder; all outputs low when disabled.
module rr_arbiter16_grant_decoder4t16
    import rr_arbiter16_pkg::*;
(
    input  logic              en_i,
    input  logic [IdxW-1:0]   w_i,
    output logic [0:NumReq-1] y_o
);

    always_comb begin
        y_o = '0;
        if (en_i) y_o[w_i] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters with hold-time limit and registered one-hot grant.
module rr_arbiter16
    import rr_arbiter16_pkg::*;
#(
    parameter int unsigned MaxHold = 8
) (
    input logic           clk_i,
    input logic           rst_i,
    rr_arbiter16_if.slave bus
);

    localparam int unsigned      CntW    = $clog2(MaxHold);
    localparam logic [CntW-1:0]  HoldMax = CntW'(MaxHold - 1);

    arb_state_t      state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] hold_q, hold_d;
    logic            timeout_q, timeout_d;
    logic            others_wait;
    logic            plain_rel;
    logic            hold_expired;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            ptr_q     <= '1;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ptr_d        = ptr_q;
        hold_d       = hold_q;
        timeout_d    = 1'b0;
        others_wait  = |(bus.req & ~(NumReq'(1) << idx_q));
        plain_rel    = bus.done | ~bus.req[idx_q] | ~bus.en;
        hold_expired = (hold_q == HoldMax) & others_wait;

        case (state_q)
            StIdle: begin
                if (bus.en && |bus.req) begin
                    state_d = StGrant;
                    idx_d   = rr_pick(bus.req, ptr_q);
                    hold_d  = '0;
                end
            end
            StGrant: begin
                if (hold_q != HoldMax) hold_d = hold_q + CntW'(1);
                if (plain_rel || hold_expired) begin
                    state_d   = StIdle;
                    ptr_d     = idx_q;
                    // Pulse only when the hold limit alone caused the release.
                    timeout_d = hold_expired & ~plain_rel;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    rr_arbiter16_grant_decoder4t16 u_decoder (
        .en_i (state_q == StGrant),
        .w_i  (idx_q),
        .y_o  (bus.grant)
    );

    assign bus.valid   = (state_q == StGrant);
    assign bus.idx     = idx_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed bench for rr_arbiter16 with a cycle-level reference model checked every cycle.
module tb_rr_arbiter16;

    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_on  = 1'b0;

    always #5 clk = ~clk;

    rr_arbiter16_if bus ();

    rr_arbiter16 #(
        .MaxHold (MAX_HOLD)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Reference model: owner (-1 = none), last owner, cycles owned so far.
    int m_owner = -1;
    int m_last  = 15;
    int m_idx   = 0;
    int m_shown = 0;
    bit m_tout  = 1'b0;

    function automatic logic [0:15] oh(input int k);
        logic [0:15] v;
        v = '0;
        if (k >= 0) v[k] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int  k;
        bit  others;
        bit  plain;
        bit  tmo;
        if (rst) begin
            m_owner <= -1;
            m_last  <= 15;
            m_idx   <= 0;
            m_shown <= 0;
            m_tout  <= 1'b0;
        end else if (m_owner < 0) begin
            m_tout <= 1'b0;
            if (bus.en && bus.req != 16'h0) begin
                k = -1;
                for (int d = 1; d <= 16; d++)
                    if (k < 0 && bus.req[(m_last + d) % 16]) k = (m_last + d) % 16;
                m_owner <= k;
                m_idx   <= k;
                m_shown <= 1;
            end
        end else begin
            others = (bus.req & ~(16'h1 << m_owner)) != 16'h0;
            plain  = bus.done || !bus.req[m_owner] || !bus.en;
            tmo    = (m_shown >= MAX_HOLD) && others;
            if (plain || tmo) begin
                m_owner <= -1;
                m_last  <= m_owner;
                m_tout  <= tmo && !plain;
            end else begin
                m_shown <= m_shown + 1;
                m_tout  <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_grant", 32'(bus.grant), 32'(oh(m_owner)));
            check("cyc_valid", 32'(bus.valid), 32'(m_owner >= 0));
            check("cyc_idx", 32'(bus.idx), 32'(m_idx));
            check("cyc_timeout", 32'(bus.timeout), 32'(m_tout));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input int owner, input int idx,
                              input bit tout);
        check({name, "_grant"}, 32'(bus.grant), 32'(oh(owner)));
        check({name, "_valid"}, 32'(bus.valid), 32'(owner >= 0));
        check({name, "_idx"}, 32'(bus.idx), 32'(idx));
        check({name, "_timeout"}, 32'(bus.timeout), 32'(tout));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        bus.en   = 1'b1;
        bus.req  = 16'hFFFF;
        bus.done = 1'b1;

        // Reset dominates all inputs.
        tick();
        chk_on = 1'b1;
        expect_out("rst1", -1, 0, 1'b0);
        tick();
        expect_out("rst2", -1, 0, 1'b0);

        rst      = 1'b0;
        bus.req  = 16'h0;
        bus.done = 1'b0;
        tick();
        expect_out("idle", -1, 0, 1'b0);

        // Single requester.
        bus.req = 16'h0020;
        tick();
        expect_out("single", 5, 5, 1'b0);
        bus.req = 16'h0;
        tick();
        expect_out("single_rel", -1, 5, 1'b0);

        // Fairness between 2 and 9 from a fresh pointer.
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        bus.req = 16'h0204;
        for (int r = 0; r < 4; r++) begin
            tick();
            expect_out("fair_own", (r % 2 == 0) ? 2 : 9, (r % 2 == 0) ? 2 : 9, 1'b0);
            bus.done = 1'b1;
            tick();
            expect_out("fair_dead", -1, (r % 2 == 0) ? 2 : 9, 1'b0);
            bus.done = 1'b0;
        end
        bus.req = 16'h0;
        tick();

        // Wrap-around from owner 15.
        bus.req = 16'h8000;
        tick();
        expect_out("wrap15", 15, 15, 1'b0);
        bus.req = 16'h0;
        tick();
        bus.req = 16'h4001;
        tick();
        expect_out("wrap0", 0, 0, 1'b0);
        bus.req = 16'h0;
        tick();

        // Hold limit with a competing requester.
        bus.req = 16'h0018;
        tick();
        expect_out("tmo_first", 3, 3, 1'b0);
        for (int c = 1; c < MAX_HOLD; c++) begin
            tick();
            expect_out("tmo_hold", 3, 3, 1'b0);
        end
        tick();
        expect_out("tmo_dead", -1, 3, 1'b1);
        check("model_last_tmo", 32'(m_last), 32'd3);
        tick();
        expect_out("tmo_next", 4, 4, 1'b0);

        // Sole requester is never cut off.
        bus.req = 16'h0008;
        tick();
        expect_out("sole_dead", -1, 4, 1'b0);
        tick();
        for (int c = 0; c < 20; c++) begin
            tick();
            expect_out("sole_hold", 3, 3, 1'b0);
        end
        bus.req = 16'h0;
        tick();

        // Abort by En=0, then by reset.
        bus.req = 16'h0080;
        tick();
        expect_out("abort_own", 7, 7, 1'b0);
        tick();
        bus.en = 1'b0;
        tick();
        expect_out("abort_en", -1, 7, 1'b0);
        bus.en = 1'b1;
        tick();
        expect_out("abort_regrant", 7, 7, 1'b0);
        rst = 1'b1;
        tick();
        expect_out("abort_rst", -1, 0, 1'b0);
        rst     = 1'b0;
        bus.req = 16'h0082;
        tick();
        expect_out("post_rst", 1, 1, 1'b0);
        check("model_owner_post_rst", 32'(m_owner), 32'd1);
        bus.req = 16'h0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
